// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, one operand bit per clock; optional signed overflow via SERIAL_ADD_OVF_EN.
// Latency: WIDTH cycles from accepted start to done; next start is accepted WIDTH+2 cycles after the previous one.
// Backpressure: none queued; start is sampled only in IDLE and ignored while busy or done.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_co, last_bit;

   // Full-adder cell on the operand LSBs and the fed-back carry.
   assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
   assign fa_co    = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
   assign s_nxt    = {fa_s, s_sr[WIDTH-1:1]};
   assign last_bit = (state == SHIFT) && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (cnt == LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == SHIFT) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            s_sr  <= s_nxt;
            carry <= fa_co;
            cnt   <= last_bit ? '0 : cnt + CW'(1);
         end
         // Results only move on the final bit, so they stay stable while busy.
         if (last_bit) begin
            sum  <= s_nxt;
            cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf  <= carry ^ fa_co;
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: scoreboard of expected results keyed by completion cycle.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk, rst, start, cin;
   logic [W-1:0] a, b, sum;
   logic         busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,.ovf  (ovf)
`endif
   );

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      int           c;
   } exp_t;

   exp_t         q[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc   = 0;
   logic [W-1:0] last_sum = '0;

   initial clk = 1'b0;
   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input int k);
      exp_t       m;
      logic [W:0] full;
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      m.s  = full[W-1:0];
      m.co = full[W];
      m.ov = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
      m.c  = k + W;
      return m;
   endfunction

   // Each done must match the oldest pending result and its predicted cycle.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
         else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.c));
            chk("sum", 32'(sum), 32'(e.s));
            chk("cout", 32'(cout), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ov));
`endif
            last_sum = e.s;
         end
      end
   end

   task automatic wait_negs(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge while the DUT is idle; returns at the negedge after the accept edge.
   task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      a = x; b = y; cin = c; start = 1'b1;
      q.push_back(model(x, y, c, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      chk("busy_after_start", 32'(busy), 32'(1));
   endtask

   initial begin
      int k0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      wait_negs(2);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
      rst = 1'b0;
      wait_negs(1);

      do_add(8'h5A, 8'h3C, 1'b0); wait_negs(W + 1);
      do_add(8'hFF, 8'h01, 1'b0); wait_negs(W + 1);
      do_add(8'hFF, 8'h00, 1'b1); wait_negs(W + 1);

      // Previous result must hold through the whole shift phase.
      do_add(8'h7F, 8'h80, 1'b1);
      for (int i = 0; i < W - 1; i++) begin
         chk("sum_held", 32'(sum), 32'(last_sum));
         wait_negs(1);
      end
      wait_negs(2);

      // Stray starts while busy at the 3rd and 8th edges after accept.
      a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
      q.push_back(model(8'h12, 8'h34, 1'b1, cyc + 1));
      wait_negs(1);
      start = 1'b0; a = 8'hAA; b = 8'hBB; cin = 1'b0;
      wait_negs(2); start = 1'b1;
      wait_negs(1); start = 1'b0;
      wait_negs(4); start = 1'b1;
      wait_negs(1); start = 1'b0;
      wait_negs(W + 4);

      // Reset in the middle of an addition discards it.
      do_add(8'h33, 8'h44, 1'b0);
      wait_negs(3);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'(0));
      chk("midrst_done", 32'(done), 32'(0));
      chk("midrst_sum", 32'(sum), 32'(0));
      chk("midrst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
      chk("midrst_ovf", 32'(ovf), 32'(0));
`endif
      q.delete();
      last_sum = '0;
      wait_negs(2);
      rst = 1'b0;
      wait_negs(W + 4);
      do_add(8'hC3, 8'h5E, 1'b1); wait_negs(W + 1);

      // start held high: one acceptance every W+2 cycles, operands refreshed before each.
      k0 = cyc + 1;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         while (cyc != k0 + (W + 2) * i - 1) @(negedge clk);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         q.push_back(model(a, b, cin, k0 + (W + 2) * i));
      end
      while (cyc != k0 + 2 * (W + 2)) @(negedge clk);
      start = 1'b0;
      wait_negs(W + 2);

      for (int i = 0; i < 4; i++) begin
         do_add(W'($urandom), W'($urandom), 1'($urandom));
         wait_negs(W + 1);
      end

      for (int i = 0; i < 50 && q.size() > 0; i++) wait_negs(1);
      chk("drain", 32'(q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
